// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a FIFO and plays them one at a
// time into an external combinational alu_8bit. The operands are held for a
// settle window. The result and carry are then returned on a valid/ready
// response channel.
// Optional feature macro: ALU_STATUS_EN adds the rsp_zero and op_count outputs.
module alu_cmd_sequencer #(
  parameter int WIDTH         = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [1:0]       rsp_sel,
`ifdef ALU_STATUS_EN
  output logic             rsp_zero,
  output logic [15:0]      op_count,
`endif
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_next;
  logic [AW:0]   rd_ptr_next;
  logic          fifo_empty;
  logic          full_next;
  logic          push;
  logic          pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign push       = cmd_valid && cmd_ready;
  assign busy       = (state != IDLE) || !fifo_empty;

  // The head is popped whenever the FSM is free to start a new command.
  // This happens when it is idle, or when the current response is being
  // accepted on this edge.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE)
        pop = 1'b1;
      else if (state == RESP && rsp_ready)
        pop = 1'b1;
    end
  end

  // Next pointer values. Full is derived from them so that cmd_ready can be
  // a plain register that reflects the post-edge occupancy.
  always_comb begin
    wr_ptr_next = wr_ptr + {{AW{1'b0}}, push};
    rd_ptr_next = rd_ptr + {{AW{1'b0}}, pop};
    full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  end

  // Pointer and ready-flag state. Reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_ready <= 1'b1;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      cmd_ready <= !full_next;
    end
  end

  // FIFO storage. Empty pointers already make stale contents unreachable,
  // so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel};
  end

  // Sequencer FSM. It drives the operands, waits out the settle window,
  // captures the ALU outputs and holds the response until it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_sel    <= '0;
`ifdef ALU_STATUS_EN
      rsp_zero   <= 1'b0;
      op_count   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a      <= head.a;
            alu_b      <= head.b;
            alu_sel    <= head.sel;
            settle_cnt <= CW'(SETTLE_CYCLES - 1);
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == '0) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_sel    <= alu_sel;
            rsp_valid  <= 1'b1;
`ifdef ALU_STATUS_EN
            rsp_zero   <= (alu_result == '0);
`endif
            state      <= RESP;
          end else begin
            settle_cnt <= settle_cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef ALU_STATUS_EN
            op_count  <= op_count + 16'd1;
`endif
            if (pop) begin
              alu_a      <= head.a;
              alu_b      <= head.b;
              alu_sel    <= head.sel;
              settle_cnt <= CW'(SETTLE_CYCLES - 1);
              state      <= DRIVE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer. It uses a small behavioural alu_8bit and a
// scoreboard queue of hand-computed responses.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [1:0] cmd_sel;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic [1:0] rsp_sel;
  logic       busy;
`ifdef ALU_STATUS_EN
  logic       rsp_zero;
  logic [15:0] op_count;
`endif

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic [1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   hs_cyc[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  alu_cmd_sequencer #(.WIDTH(8), .FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_sel(rsp_sel),
`ifdef ALU_STATUS_EN
    .rsp_zero(rsp_zero), .op_count(op_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural alu_8bit: carry is the add carry-out, or the borrow for sub.
  always_comb begin
    alu_carry  = 1'b0;
    alu_result = 8'h00;
    case (alu_sel)
      2'b00: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every response handshake is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_response", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rsp_sel_carry_result", {21'd0, rsp_sel, rsp_carry, rsp_result},
                    {21'd0, mon_e.sel, mon_e.carry, mon_e.res});
`ifdef ALU_STATUS_EN
        checkOutput("rsp_zero", {31'd0, rsp_zero}, {31'd0, (mon_e.res == 8'h00)});
`endif
        hs_cyc.push_back(cyc);
      end
    end
  end

  // One single-cycle push attempt. The expectation is queued only if the
  // command was taken.
  task automatic tryPush(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                         input logic [7:0] res, input logic carry, output bit acc);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = sel;
    @(negedge clk);
    acc = cmd_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      e.res   = res;
      e.carry = carry;
      e.sel   = sel;
      exp_q.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                               input logic [7:0] res, input logic carry);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      tryPush(a, b, sel, res, carry, acc);
      n++;
    end
    if (!acc) checkOutput("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic waitRspValid(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_rsp_valid_seen"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  logic [7:0] v4a[8] = '{8'd1, 8'd9, 8'h0F, 8'h0F, 8'd200, 8'd5, 8'd6, 8'd7};
  logic [7:0] v4b[8] = '{8'd2, 8'd4, 8'h3C, 8'h30, 8'd100, 8'd5, 8'd6, 8'd7};
  logic [1:0] v4s[8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [7:0] v4r[8] = '{8'd3, 8'd5, 8'h0C, 8'h3F, 8'h2C, 8'd10, 8'd12, 8'd14};
  logic       v4c[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int  n_acc;
    bit  acc;
    bit  quiet;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("reset_rsp_valid_busy", {30'd0, rsp_valid, busy}, 32'd0);
    checkOutput("reset_alu", {14'd0, alu_sel, alu_b, alu_a}, 32'd0);
    checkOutput("reset_rsp", {21'd0, rsp_sel, rsp_carry, rsp_result}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] test 1: 10+5 latency");
    applyStimulus(8'd10, 8'd5, 2'b00, 8'd15, 1'b0);
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t1_valid_after_1", {31'd0, rsp_valid}, 32'd0);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("t1_valid_after_2", {31'd0, rsp_valid}, 32'd1);
    waitDrain("t1");

    $display("[TB] test 2: 255+1 overflow");
    applyStimulus(8'd255, 8'd1, 2'b00, 8'd0, 1'b1);
    cmd_valid = 1'b0;
    waitDrain("t2");
`ifdef ALU_STATUS_EN
    checkOutput("t2_op_count", {16'd0, op_count}, 32'd2);
`endif

    $display("[TB] test 3: back-to-back commands");
    hs_cyc.delete();
    applyStimulus(8'd20, 8'd4, 2'b01, 8'd16, 1'b0);
    applyStimulus(8'hAA, 8'hF0, 2'b10, 8'hA0, 1'b0);
    applyStimulus(8'hAA, 8'hF0, 2'b11, 8'hFA, 1'b0);
    applyStimulus(8'd3, 8'd4, 2'b00, 8'd7, 1'b0);
    cmd_valid = 1'b0;
    waitDrain("t3");
    checkOutput("t3_response_count", hs_cyc.size(), 32'd4);
    for (int i = 1; i < hs_cyc.size(); i++)
      checkOutput("t3_response_gap", hs_cyc[i] - hs_cyc[i-1], 32'd2);

    $display("[TB] test 4: capacity with rsp_ready low");
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      tryPush(v4a[i], v4b[i], v4s[i], v4r[i], v4c[i], acc);
      if (acc) n_acc++;
    end
    cmd_valid = 1'b0;
    checkOutput("t4_accepted", n_acc, 32'd5);
    checkOutput("t4_cmd_ready_full", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4_cmd_ready_after_pop", {31'd0, cmd_ready}, 32'd1);
    waitDrain("t4");

    $display("[TB] test 5: response hold");
    rsp_ready = 1'b0;
    applyStimulus(8'd100, 8'd30, 2'b01, 8'd70, 1'b0);
    applyStimulus(8'd7, 8'd3, 2'b10, 8'd3, 1'b0);
    cmd_valid = 1'b0;
    waitRspValid("t5");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t5_hold", {2'd0, rsp_valid, alu_sel, alu_b, alu_a, rsp_sel, rsp_carry, rsp_result},
                  {2'd0, 1'b1, 2'b01, 8'd30, 8'd100, 2'b01, 1'b0, 8'd70});
    end
    rsp_ready = 1'b1;
    waitDrain("t5");

    $display("[TB] test 6: reset while driving");
    rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 1; i <= 5; i++) begin
      tryPush(8'(i), 8'(i), 2'b00, 8'(2 * i), 1'b0, acc);
      if (acc) n_acc++;
    end
    cmd_valid = 1'b0;
    checkOutput("t6_accepted", n_acc, 32'd5);
    waitRspValid("t6");
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("t6_driving_second", {24'd0, alu_a}, 32'd2);
    rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput("t6_reset_flags", {29'd0, rsp_valid, busy, cmd_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    quiet     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) quiet = 1'b0;
    end
    checkOutput("t6_no_replay", {31'd0, quiet}, 32'd1);
`ifdef ALU_STATUS_EN
    checkOutput("t6_op_count_reset", {16'd0, op_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
